// File: rtl/chiplib_riscv_plic_gateway_array.sv
// PLIC gateway array: one gateway per interrupt source ID 1..NumSrc.
// Each gateway turns a raw IRQ line (level or pulse, sync or async) into a
// single pending bit for the PLIC core. The gateway then tracks the core's
// claim and complete handshake for that source ID.
module chiplib_riscv_plic_gateway_array #(
  parameter int unsigned        NumSrc     = 32,
  parameter logic [NumSrc-1:0]  PulseMask  = '0,
  parameter logic [NumSrc-1:0]  AsyncMask  = '0,
  parameter int unsigned        SyncStages = 2,
  parameter int unsigned        PulseCntW  = 3,
  localparam int unsigned       IdW        = $clog2(NumSrc + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NumSrc-1:0] irq_in,
  input  logic              claim_valid,
  input  logic [IdW-1:0]    claim_id,
  input  logic              complete_valid,
  input  logic [IdW-1:0]    complete_id,
  output logic [NumSrc-1:0] irq_pend,
  output logic [NumSrc-1:0] irq_overflow
);

  typedef enum logic [1:0] {
    Idle    = 2'd0,
    Pending = 2'd1,
    Claimed = 2'd2
  } state_e;

  for (genvar g = 0; g < NumSrc; g++) begin : gen_src
    // Source IDs start at 1; ID 0 is reserved and never matches any gateway.
    localparam logic [IdW-1:0] SrcId = IdW'(g + 1);

    state_e state_q, state_d;
    logic   srcLevel;
    logic   claimHit;
    logic   completeHit;
    logic   ovfBit;

    // A claim only counts when this source is Pending, and a complete only
    // counts when it is Claimed. Any other ID, or a stale or duplicate
    // request, falls through as a no-op.
    assign claimHit    = claim_valid    && (claim_id    == SrcId) && (state_q == Pending);
    assign completeHit = complete_valid && (complete_id == SrcId) && (state_q == Claimed);

    if (AsyncMask[g]) begin : gen_async
      logic [SyncStages-1:0] sync_q;

      // Shift the raw line through the synchroniser chain.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SyncStages-2:0], irq_in[g]};
      end

      assign srcLevel = sync_q[SyncStages-1];
    end else begin : gen_sync
      assign srcLevel = irq_in[g];
    end

    if (PulseMask[g]) begin : gen_pulse
      localparam logic [PulseCntW-1:0] CntMax = '1;

      logic                 prev_q;
      logic [PulseCntW-1:0] cnt_q, cnt_d;
      logic                 ovf_q, ovf_d;
      logic                 edgeSeen;
      logic                 haveWork;
      logic                 consume;

      assign edgeSeen = srcLevel & ~prev_q;
      assign haveWork = edgeSeen || (cnt_q != '0);

      // Consume one edge on each move into Pending. Queued edges are used
      // first, so a fresh edge in that same cycle takes the freed slot.
      // Any other edge joins the queue, or is dropped (and flagged) when the
      // queue is full.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        consume = 1'b0;
        case (state_q)
          Idle: begin
            if (haveWork) begin
              state_d = Pending;
              consume = 1'b1;
            end
          end
          Pending: begin
            if (claimHit) state_d = Claimed;
          end
          Claimed: begin
            if (completeHit) begin
              ovf_d = 1'b0;
              if (haveWork) begin
                state_d = Pending;
                consume = 1'b1;
              end else begin
                state_d = Idle;
              end
            end
          end
          default: state_d = Idle;
        endcase
        if (consume && (cnt_q != '0)) begin
          if (!edgeSeen) cnt_d = cnt_q - PulseCntW'(1);
        end else if (!consume && edgeSeen) begin
          if (cnt_q == CntMax) ovf_d = 1'b1;
          else                 cnt_d = cnt_q + PulseCntW'(1);
        end
      end

      // Edge-detect history, edge queue and sticky overflow flag.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev_q <= 1'b0;
          cnt_q  <= '0;
          ovf_q  <= 1'b0;
        end else begin
          prev_q <= srcLevel;
          cnt_q  <= cnt_d;
          ovf_q  <= ovf_d;
        end
      end

      assign ovfBit = ovf_q;
    end else begin : gen_level
      // A level source re-pends on complete only if the line is still high.
      // While Pending or Claimed, the line level is ignored.
      always_comb begin
        state_d = state_q;
        case (state_q)
          Idle: begin
            if (srcLevel) state_d = Pending;
          end
          Pending: begin
            if (claimHit) state_d = Claimed;
          end
          Claimed: begin
            if (completeHit) state_d = srcLevel ? Pending : Idle;
          end
          default: state_d = Idle;
        endcase
      end

      assign ovfBit = 1'b0;
    end

    // Gateway state register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= Idle;
      else        state_q <= state_d;
    end

    assign irq_pend[g]     = (state_q == Pending);
    assign irq_overflow[g] = ovfBit;
  end

endmodule

// File: tb/tb_chiplib_riscv_plic_gateway_array.sv
// Self-checking bench for the PLIC gateway array.
// Instance: 8 sources.
//   Pulse sources: 1, 6 and 8.
//   Async sources: 7 and 8.
//   Two-stage synchroniser; 2-bit edge counter (at most 3 queued edges).
// The reference model counts the edges available to each source and tracks
// each source's state as a plain integer.
module tb_chiplib_riscv_plic_gateway_array;

  localparam int N     = 8;
  localparam int SS    = 2;
  localparam int MAXC  = 3;
  localparam logic [N-1:0] PMASK = 8'hA1;
  localparam logic [N-1:0] AMASK = 8'hC0;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] irq_in;
  logic         claim_valid;
  logic [3:0]   claim_id;
  logic         complete_valid;
  logic [3:0]   complete_id;
  logic [N-1:0] irq_pend;
  logic [N-1:0] irq_overflow;

  int errors;
  int checks;

  // Reference model state: 0 = idle, 1 = waiting for claim, 2 = in service.
  int           mSt[N];
  int           mCnt[N];
  logic [N-1:0] mOvf;
  logic [N-1:0] mPrev;
  logic [N-1:0] mHist[SS];
  logic [N-1:0] expPend;
  logic [N-1:0] expOvf;

  chiplib_riscv_plic_gateway_array #(
    .NumSrc(N), .PulseMask(PMASK), .AsyncMask(AMASK),
    .SyncStages(SS), .PulseCntW(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in),
    .claim_valid(claim_valid), .claim_id(claim_id),
    .complete_valid(complete_valid), .complete_id(complete_id),
    .irq_pend(irq_pend), .irq_overflow(irq_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clear the model as a reset does.
  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      mSt[i]  = 0;
      mCnt[i] = 0;
    end
    mOvf = '0;
    mPrev = '0;
    for (int d = 0; d < SS; d++) mHist[d] = '0;
    expPend = '0;
    expOvf = '0;
  endtask

  // Advance the model by one clock edge, using the inputs held for that edge.
  task automatic modelStep(input logic [N-1:0] irq, input logic cv, input logic [3:0] cid,
                           input logic dv, input logic [3:0] did);
    for (int i = 0; i < N; i++) begin
      logic s;
      logic e;
      logic claim;
      logic comp;
      int   avail;
      s     = AMASK[i] ? mHist[SS-1][i] : irq[i];
      claim = cv && (int'(cid) == i + 1) && (mSt[i] == 1);
      comp  = dv && (int'(did) == i + 1) && (mSt[i] == 2);
      if (!PMASK[i]) begin
        if (mSt[i] == 0) begin
          if (s) mSt[i] = 1;
        end else if (claim) mSt[i] = 2;
        else if (comp) mSt[i] = s ? 1 : 0;
      end else begin
        e = s && !mPrev[i];
        mPrev[i] = s;
        avail = mCnt[i] + (e ? 1 : 0);
        if (mSt[i] == 0) begin
          if (avail > 0) begin
            mSt[i] = 1;
            avail--;
          end
        end else if (claim) begin
          mSt[i] = 2;
        end else if (comp) begin
          mOvf[i] = 1'b0;
          if (avail > 0) begin
            mSt[i] = 1;
            avail--;
          end else mSt[i] = 0;
        end
        if (avail > MAXC) begin
          avail = MAXC;
          mOvf[i] = 1'b1;
        end
        mCnt[i] = avail;
      end
    end
    for (int d = SS - 1; d > 0; d--) mHist[d] = mHist[d-1];
    mHist[0] = irq;
    for (int i = 0; i < N; i++) expPend[i] = (mSt[i] == 1);
    expOvf = mOvf;
  endtask

  // Drive one cycle of inputs, update the model, then settle just after the edge.
  task automatic step(input logic [N-1:0] irq, input logic cv, input logic [3:0] cid,
                      input logic dv, input logic [3:0] did);
    irq_in = irq;
    claim_valid = cv;
    claim_id = cid;
    complete_valid = dv;
    complete_id = did;
    modelStep(irq, cv, cid, dv, did);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    irq_in = '0;
    claim_valid = 1'b0;
    claim_id = '0;
    complete_valid = 1'b0;
    complete_id = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (irq_pend !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_pend got=%h exp=00", irq_pend);
    end
    checks++;
    if (irq_overflow !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_ovf got=%h exp=00", irq_overflow);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_level_sync();
    step(8'h04, 0, 0, 0, 0);
    checks++;
    if (irq_pend[2] !== 1'b1 || irq_pend !== expPend) begin
      errors++;
      $display("[TB] FAIL level_rise got=%h exp=%h", irq_pend, expPend);
    end
    step(8'h04, 1, 3, 0, 0);
    checks++;
    if (irq_pend[2] !== 1'b0 || irq_pend !== expPend) begin
      errors++;
      $display("[TB] FAIL level_claim got=%h exp=%h", irq_pend, expPend);
    end
    step(8'h04, 0, 0, 1, 3);
    checks++;
    if (irq_pend[2] !== 1'b1 || irq_pend !== expPend) begin
      errors++;
      $display("[TB] FAIL level_repend got=%h exp=%h", irq_pend, expPend);
    end
    step(8'h04, 1, 3, 0, 0);
    step(8'h00, 0, 0, 1, 3);
    checks++;
    if (irq_pend !== 8'h00 || irq_pend !== expPend) begin
      errors++;
      $display("[TB] FAIL level_idle got=%h exp=%h", irq_pend, expPend);
    end
  endtask

  task automatic test_pulse_overflow();
    step(8'h01, 0, 0, 0, 0);
    step(8'h00, 1, 1, 0, 0);
    for (int p = 0; p < 5; p++) begin
      step(8'h01, 0, 0, 0, 0);
      step(8'h00, 0, 0, 0, 0);
    end
    checks++;
    if (irq_overflow[0] !== 1'b1 || irq_pend[0] !== 1'b0 || irq_overflow !== expOvf) begin
      errors++;
      $display("[TB] FAIL pulse_ovf_set got=%h/%h exp ovf=%h", irq_overflow, irq_pend, expOvf);
    end
    for (int r = 0; r < 3; r++) begin
      step(8'h00, 0, 0, 1, 1);
      checks++;
      if (irq_pend[0] !== 1'b1 || irq_overflow[0] !== 1'b0 || irq_pend !== expPend) begin
        errors++;
        $display("[TB] FAIL pulse_round%0d pend=%h ovf=%h exp pend=%h", r, irq_pend, irq_overflow, expPend);
      end
      step(8'h00, 1, 1, 0, 0);
    end
    step(8'h00, 0, 0, 1, 1);
    checks++;
    if (irq_pend[0] !== 1'b0 || irq_pend !== expPend) begin
      errors++;
      $display("[TB] FAIL pulse_drained got=%h exp=%h", irq_pend, expPend);
    end
  endtask

  task automatic test_async();
    logic [2:0] seen;
    for (int k = 0; k < 3; k++) begin
      step(8'h40, 0, 0, 0, 0);
      seen[k] = irq_pend[6];
    end
    checks++;
    if (seen !== 3'b100 || irq_pend !== expPend) begin
      errors++;
      $display("[TB] FAIL async_latency got=%b exp=100", seen);
    end
    step(8'h40, 1, 7, 0, 0);
    step(8'h00, 0, 0, 0, 0);
    step(8'h00, 0, 0, 0, 0);
    step(8'h00, 0, 0, 1, 7);
    checks++;
    if (irq_pend[6] !== 1'b0 || irq_pend !== expPend) begin
      errors++;
      $display("[TB] FAIL async_complete got=%h exp=%h", irq_pend, expPend);
    end
    step(8'h40, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    irq_in = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(8'h00, 0, 0, 0, 0);
      checks++;
      if (irq_pend !== 8'h00 || irq_pend !== expPend) begin
        errors++;
        $display("[TB] FAIL async_reset_sync%0d got=%h exp=00", k, irq_pend);
      end
    end
  endtask

  task automatic test_illegal_ids();
    logic [3:0] badIds[4];
    badIds[0] = 4'd0;
    badIds[1] = 4'd9;
    badIds[2] = 4'd15;
    badIds[3] = 4'd5;
    step(8'h02, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(8'h02, 1, badIds[k], 0, 0);
      checks++;
      if (irq_pend !== 8'h02 || irq_pend !== expPend) begin
        errors++;
        $display("[TB] FAIL bad_claim_id%0d got=%h exp=02", badIds[k], irq_pend);
      end
    end
    step(8'h02, 0, 0, 1, 2);
    checks++;
    if (irq_pend !== 8'h02 || irq_pend !== expPend) begin
      errors++;
      $display("[TB] FAIL complete_pending got=%h exp=02", irq_pend);
    end
    step(8'h02, 1, 2, 0, 0);
    step(8'h00, 0, 0, 1, 2);
    checks++;
    if (irq_pend !== 8'h00 || irq_pend !== expPend) begin
      errors++;
      $display("[TB] FAIL illegal_cleanup got=%h exp=00", irq_pend);
    end
  endtask

  task automatic test_same_cycle();
    step(8'h08, 0, 0, 0, 0);
    step(8'h08, 1, 4, 1, 4);
    checks++;
    if (irq_pend[3] !== 1'b0 || irq_pend !== expPend) begin
      errors++;
      $display("[TB] FAIL same_id_claim got=%h exp=%h", irq_pend, expPend);
    end
    step(8'h08, 0, 0, 0, 0);
    checks++;
    if (irq_pend[3] !== 1'b0 || irq_pend !== expPend) begin
      errors++;
      $display("[TB] FAIL same_id_held got=%h exp=%h", irq_pend, expPend);
    end
    step(8'h08, 0, 0, 1, 4);
    checks++;
    if (irq_pend[3] !== 1'b1 || irq_pend !== expPend) begin
      errors++;
      $display("[TB] FAIL same_id_later_complete got=%h exp=%h", irq_pend, expPend);
    end
    step(8'h08, 1, 4, 0, 0);
    step(8'h0A, 0, 0, 0, 0);
    step(8'h0A, 1, 2, 1, 4);
    checks++;
    if (irq_pend !== 8'h08 || irq_pend !== expPend) begin
      errors++;
      $display("[TB] FAIL diff_id_both got=%h exp=08", irq_pend);
    end
    step(8'h00, 1, 4, 0, 0);
    step(8'h00, 0, 0, 1, 2);
    step(8'h00, 0, 0, 1, 4);
    checks++;
    if (irq_pend !== 8'h00 || irq_pend !== expPend) begin
      errors++;
      $display("[TB] FAIL same_cycle_cleanup got=%h exp=00", irq_pend);
    end
  endtask

  task automatic test_coincident_edge();
    step(8'h20, 0, 0, 0, 0);
    step(8'h00, 1, 6, 0, 0);
    step(8'h20, 0, 0, 0, 0);
    step(8'h00, 0, 0, 0, 0);
    step(8'h20, 0, 0, 1, 6);
    checks++;
    if (irq_pend[5] !== 1'b1 || irq_overflow[5] !== 1'b0 || irq_pend !== expPend) begin
      errors++;
      $display("[TB] FAIL coincide_cnt1 pend=%h ovf=%h exp=%h", irq_pend, irq_overflow, expPend);
    end
    step(8'h00, 1, 6, 0, 0);
    for (int p = 0; p < 3; p++) begin
      step(8'h20, 0, 0, 0, 0);
      step(8'h00, 0, 0, 0, 0);
    end
    step(8'h20, 0, 0, 1, 6);
    checks++;
    if (irq_pend[5] !== 1'b1 || irq_overflow[5] !== 1'b0 || irq_overflow !== expOvf) begin
      errors++;
      $display("[TB] FAIL coincide_full pend=%h ovf=%h exp ovf=%h", irq_pend, irq_overflow, expOvf);
    end
    for (int r = 0; r < 5; r++) begin
      step(8'h00, 1, 6, 0, 0);
      step(8'h00, 0, 0, 1, 6);
      checks++;
      if (irq_pend !== expPend || irq_overflow !== expOvf) begin
        errors++;
        $display("[TB] FAIL coincide_drain%0d pend=%h exp=%h", r, irq_pend, expPend);
      end
    end
    checks++;
    if (irq_pend !== 8'h00) begin
      errors++;
      $display("[TB] FAIL coincide_idle got=%h exp=00", irq_pend);
    end
  endtask

  task automatic test_reset_mid_claimed();
    step(8'h05, 0, 0, 0, 0);
    step(8'h04, 1, 1, 0, 0);
    for (int p = 0; p < 4; p++) begin
      step(8'h05, 0, 0, 0, 0);
      step(8'h04, 0, 0, 0, 0);
    end
    checks++;
    if (irq_overflow !== 8'h01 || irq_pend !== 8'h04) begin
      errors++;
      $display("[TB] FAIL pre_reset pend=%h ovf=%h exp 04/01", irq_pend, irq_overflow);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (irq_pend !== 8'h00 || irq_overflow !== 8'h00) begin
      errors++;
      $display("[TB] FAIL async_reset pend=%h ovf=%h exp 00/00", irq_pend, irq_overflow);
    end
    irq_in = '0;
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step(N'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)));
      checks++;
      if (irq_pend !== expPend || irq_overflow !== expOvf) begin
        errors++;
        $display("[TB] FAIL random_c%0d pend=%h/%h ovf=%h/%h", c, irq_pend, expPend, irq_overflow, expOvf);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_level_sync();
    test_pulse_overflow();
    test_async();
    test_illegal_ids();
    test_same_cycle();
    test_coincident_edge();
    test_reset_mid_claimed();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
